// File: rtl/spi_flash_read_master.sv
// SPI mode-0 flash read master: issues 0xAB release-power-down after reset,
// then serves 32-bit word reads with 0x03 + 24-bit address + 32 data clocks.
module spi_flash_read_master #(
    parameter int CLK_DIV   = 1,
    parameter int CS_GAP    = 2,
    parameter int WAKE_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_d0,
    input  logic        flash_d1,
    output logic        busy
);

    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = $clog2(WAKE_WAIT + CS_GAP + 2);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAKE_LOAD = WAIT_W'(WAKE_WAIT + CS_GAP - 1);
    localparam logic [WAIT_W-1:0] GAP_LOAD  = WAIT_W'(CS_GAP);
    localparam logic [7:0]        WAKE_CMD  = 8'hAB;
    localparam logic [7:0]        READ_CMD  = 8'h03;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_WAKE_WAIT,
        ST_IDLE,
        ST_XFER,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [63:0]       tx_q, tx_d;
    logic [31:0]       rx_q, rx_d;
    logic              clk_d, csn_d, d0_d;
    logic              ready_d, rsp_valid_d, busy_d;
    logic [31:0]       rsp_data_d;
    logic [6:0]        last_bit;
    logic              half_done;
    logic              xfer_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAKE;
            bit_cnt_q  <= '0;
            half_cnt_q <= '0;
            wait_cnt_q <= '0;
            tx_q       <= {WAKE_CMD, 56'h0};
            rx_q       <= '0;
            flash_clk  <= 1'b0;
            flash_csn  <= 1'b1;
            flash_d0   <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            half_cnt_q <= half_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            flash_clk  <= clk_d;
            flash_csn  <= csn_d;
            flash_d0   <= d0_d;
            req_ready  <= ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        half_cnt_d  = half_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        clk_d       = flash_clk;
        csn_d       = flash_csn;
        d0_d        = flash_d0;
        ready_d     = req_ready;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        busy_d      = busy;
        xfer_end    = 1'b0;
        last_bit    = (state_q == ST_WAKE) ? 7'd7 : 7'd63;
        half_done   = (half_cnt_q == HALF_LAST);

        // Bit engine: runs whenever chip select is active; MISO is taken in
        // the first cycle of each high phase of the 32 receive bits.
        if (!flash_csn) begin
            if (state_q == ST_XFER && flash_clk && half_cnt_q == '0 && bit_cnt_q[5])
                rx_d = {rx_q[30:0], flash_d1};
            if (!half_done) begin
                half_cnt_d = half_cnt_q + HALF_W'(1);
            end else begin
                half_cnt_d = '0;
                if (!flash_clk) begin
                    clk_d = 1'b1;
                end else begin
                    clk_d = 1'b0;
                    if (bit_cnt_q == last_bit) begin
                        xfer_end = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        tx_d      = {tx_q[62:0], 1'b0};
                        d0_d      = tx_q[62];
                    end
                end
            end
        end

        case (state_q)
            ST_WAKE: begin
                if (flash_csn) begin
                    csn_d = 1'b0;
                    d0_d  = tx_q[63];
                end else if (xfer_end) begin
                    csn_d      = 1'b1;
                    d0_d       = 1'b0;
                    wait_cnt_d = WAKE_LOAD;
                    state_d    = ST_WAKE_WAIT;
                end
            end
            ST_WAKE_WAIT: begin
                if (wait_cnt_q == '0) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    csn_d      = 1'b0;
                    clk_d      = 1'b0;
                    tx_d       = {READ_CMD, req_addr, 32'h0};
                    d0_d       = READ_CMD[7];
                    bit_cnt_d  = '0;
                    half_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                // Bytes arrive MSB first; first byte lands in the low lane.
                if (xfer_end) begin
                    csn_d       = 1'b1;
                    d0_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
                    wait_cnt_d  = GAP_LOAD;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (wait_cnt_q == '0) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_WAKE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_read_master.sv
// Self-checking bench for spi_flash_read_master: two instances (CLK_DIV 1 and 3),
// behavioural mode-0 flash on MISO, MOSI decoder and a response scoreboard.
module tb_spi_flash_read_master;

    localparam int DIV_A    = 1;
    localparam int DIV_B    = 3;
    localparam int GAP_CYC  = 2;
    localparam int WAKE_CYC = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] hdr;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        req_valid1 = 1'b0, req_valid3 = 1'b0;
    logic [23:0] req_addr1 = '0, req_addr3 = '0;
    logic        req_ready1, req_ready3, rsp_valid1, rsp_valid3;
    logic [31:0] rsp_data1, rsp_data3;
    logic        fclk1, fcsn1, fd0_1, fd1_1, busy1;
    logic        fclk3, fcsn3, fd0_3, fd1_3, busy3;

    logic [31:0] miso_word1 = '0, miso_word3 = '0;
    int          falls1 = 0, falls3 = 0;
    logic [63:0] mosi1 = '0, mosi3 = '0;
    int          nbits1 = 0, nbits3 = 0;
    int          run3 = 0, run_min3 = 1000, run_max3 = 0;
    logic        prev_clk3 = 1'b0, prev_csn3 = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_flash_read_master #(.CLK_DIV(DIV_A), .CS_GAP(GAP_CYC), .WAKE_WAIT(WAKE_CYC)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .flash_clk(fclk1), .flash_csn(fcsn1), .flash_d0(fd0_1), .flash_d1(fd1_1),
        .busy(busy1)
    );

    spi_flash_read_master #(.CLK_DIV(DIV_B), .CS_GAP(GAP_CYC), .WAKE_WAIT(WAKE_CYC)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .flash_clk(fclk3), .flash_csn(fcsn3), .flash_d0(fd0_3), .flash_d1(fd1_3),
        .busy(busy3)
    );

    // Flash model: shifts the next data bit out on each falling SPI clock.
    always @(negedge fcsn1) falls1 = 0;
    always @(negedge fclk1) falls1++;
    always @(negedge fcsn3) falls3 = 0;
    always @(negedge fclk3) falls3++;
    always_comb fd1_1 = (falls1 >= 32 && falls1 < 64) ? miso_word1[63 - falls1] : 1'b0;
    always_comb fd1_3 = (falls3 >= 32 && falls3 < 64) ? miso_word3[63 - falls3] : 1'b0;

    always @(negedge fcsn1) begin mosi1 = '0; nbits1 = 0; end
    always @(posedge fclk1) begin mosi1 = {mosi1[62:0], fd0_1}; nbits1++; end
    always @(negedge fcsn3) begin mosi3 = '0; nbits3 = 0; end
    always @(posedge fclk3) begin mosi3 = {mosi3[62:0], fd0_3}; nbits3++; end

    always @(negedge clk) begin
        if (!fcsn3) begin
            if (prev_csn3) begin
                run3 = 1;
            end else if (fclk3 == prev_clk3) begin
                run3++;
            end else begin
                if (run3 < run_min3) run_min3 = run3;
                if (run3 > run_max3) run_max3 = run3;
                run3 = 1;
            end
        end else if (!prev_csn3) begin
            if (run3 < run_min3) run_min3 = run3;
            if (run3 > run_max3) run_max3 = run3;
        end
        prev_clk3 = fclk3;
        prev_csn3 = fcsn3;
    end

    function automatic logic [31:0] le_word(input logic [31:0] stream);
        return {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
    endfunction

    // Drives one request on instance 1 and waits for its response (bounded).
    task automatic do_read1(input logic [23:0] addr, input logic [31:0] word, input bit hold,
                            output int acc, output int lat, output logic [1:0] t1_state);
        int guard;
        miso_word1 = word;
        req_addr1  = addr;
        req_valid1 = 1'b1;
        guard = 0;
        while (!req_ready1 && guard < 2000) begin @(negedge clk); guard++; end
        acc = cyc;
        @(negedge clk);
        t1_state = {fcsn1, req_ready1};
        if (!hold) req_valid1 = 1'b0;
        req_addr1 = ~addr;
        lat = 1;
        while (!rsp_valid1 && lat < 2000) begin @(negedge clk); lat++; end
    endtask

    task automatic do_read3(input logic [23:0] addr, input logic [31:0] word,
                            output int acc, output int lat);
        int guard;
        miso_word3 = word;
        req_addr3  = addr;
        req_valid3 = 1'b1;
        guard = 0;
        while (!req_ready3 && guard < 2000) begin @(negedge clk); guard++; end
        acc = cyc;
        @(negedge clk);
        req_valid3 = 1'b0;
        req_addr3  = ~addr;
        lat = 1;
        while (!rsp_valid3 && lat < 4000) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({fcsn1, fclk1, fd0_1, req_ready1, rsp_valid1, busy1} !== 6'b100001) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {fcsn1, fclk1, fd0_1, req_ready1, rsp_valid1, busy1}, 6'b100001);
        end
        n_cmp++;
        if (rsp_data1 !== 32'h0) begin
            n_bad++; $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", rsp_data1);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fcsn1 !== 1'b0) begin
            n_bad++; $display("[TB] FAIL wake_csn_fall: got %b expected 0", fcsn1);
        end
        k = 0;
        while (fcsn1 === 1'b0 && k < 200) begin @(negedge clk); k++; end
        n_cmp++;
        if (k !== 16 * DIV_A) begin
            n_bad++; $display("[TB] FAIL wake_length: got %0d expected %0d", k, 16 * DIV_A);
        end
        n_cmp++;
        if (nbits1 !== 8 || mosi1[7:0] !== 8'hAB) begin
            n_bad++; $display("[TB] FAIL wake_cmd: got %0d bits %h expected 8 bits ab", nbits1, mosi1[7:0]);
        end
        k = 0;
        while (!req_ready1 && k < 200) begin @(negedge clk); k++; end
        n_cmp++;
        if (k !== WAKE_CYC + GAP_CYC) begin
            n_bad++; $display("[TB] FAIL wake_ready_delay: got %0d expected %0d", k, WAKE_CYC + GAP_CYC);
        end
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_bad++; $display("[TB] FAIL idle_busy: got %b expected 0", busy1);
        end
    endtask

    task automatic test_single_read();
        int acc, lat;
        logic [1:0] t1;
        exp_t e;
        exp_q.push_back('{data: 32'hEFBE3713, hdr: 32'h03000100});
        do_read1(24'h000100, {8'h13, 8'h37, 8'hBE, 8'hEF}, 1'b0, acc, lat, t1);
        e = exp_q.pop_front();
        n_cmp++;
        if (t1 !== 2'b00) begin
            n_bad++; $display("[TB] FAIL single_accept_state: got csn/ready %b expected 00", t1);
        end
        n_cmp++;
        if (lat !== 1 + 128 * DIV_A) begin
            n_bad++; $display("[TB] FAIL single_latency: got %0d expected %0d", lat, 1 + 128 * DIV_A);
        end
        n_cmp++;
        if (rsp_data1 !== e.data) begin
            n_bad++; $display("[TB] FAIL single_data: got %h expected %h", rsp_data1, e.data);
        end
        n_cmp++;
        if (mosi1[63:32] !== e.hdr || nbits1 !== 64) begin
            n_bad++; $display("[TB] FAIL single_mosi_hdr: got %h (%0d bits) expected %h (64 bits)",
                              mosi1[63:32], nbits1, e.hdr);
        end
        n_cmp++;
        if (mosi1[31:0] !== 32'h0) begin
            n_bad++; $display("[TB] FAIL single_mosi_idle: got %h expected 00000000", mosi1[31:0]);
        end
        n_cmp++;
        if ({fcsn1, fclk1} !== 2'b10) begin
            n_bad++; $display("[TB] FAIL single_end_pins: got %b expected 10", {fcsn1, fclk1});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid1 !== 1'b0 || rsp_data1 !== e.data) begin
            n_bad++; $display("[TB] FAIL single_pulse: got valid %b data %h expected 0 %h",
                              rsp_valid1, rsp_data1, e.data);
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, lat, gap;
        logic [1:0] t1;
        logic [23:0] a1, a2;
        logic [31:0] w1, w2;
        exp_t e;
        a1 = 24'h0A0B0C; w1 = 32'h11223344;
        a2 = 24'h55AA33; w2 = 32'hDEADBEEF;
        exp_q.push_back('{data: le_word(w1), hdr: {8'h03, a1}});
        do_read1(a1, w1, 1'b1, acc1, lat, t1);
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_data1 !== e.data || mosi1[63:32] !== e.hdr) begin
            n_bad++; $display("[TB] FAIL b2b_first: got %h hdr %h expected %h hdr %h",
                              rsp_data1, mosi1[63:32], e.data, e.hdr);
        end
        gap = 0;
        while (!req_ready1 && gap < 100) begin
            @(negedge clk);
            if (!req_ready1 && fcsn1) gap++;
        end
        exp_q.push_back('{data: le_word(w2), hdr: {8'h03, a2}});
        do_read1(a2, w2, 1'b0, acc2, lat, t1);
        e = exp_q.pop_front();
        n_cmp++;
        if (gap !== GAP_CYC) begin
            n_bad++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", gap, GAP_CYC);
        end
        n_cmp++;
        if (acc2 - acc1 !== 2 + 128 * DIV_A + GAP_CYC) begin
            n_bad++; $display("[TB] FAIL b2b_interval: got %0d expected %0d",
                              acc2 - acc1, 2 + 128 * DIV_A + GAP_CYC);
        end
        n_cmp++;
        if (rsp_data1 !== e.data || mosi1[63:32] !== e.hdr) begin
            n_bad++; $display("[TB] FAIL b2b_second: got %h hdr %h expected %h hdr %h",
                              rsp_data1, mosi1[63:32], e.data, e.hdr);
        end
    endtask

    task automatic test_clkdiv3();
        int acc, lat;
        exp_t e;
        run_min3 = 1000;
        run_max3 = 0;
        exp_q.push_back('{data: le_word(32'h0F1E2D3C), hdr: 32'h03ABCDEF});
        do_read3(24'hABCDEF, 32'h0F1E2D3C, acc, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== 1 + 128 * DIV_B) begin
            n_bad++; $display("[TB] FAIL div3_latency: got %0d expected %0d", lat, 1 + 128 * DIV_B);
        end
        n_cmp++;
        if (mosi3[63:32] !== e.hdr || nbits3 !== 64) begin
            n_bad++; $display("[TB] FAIL div3_mosi: got %h (%0d bits) expected %h", mosi3[63:32], nbits3, e.hdr);
        end
        n_cmp++;
        if (rsp_data3 !== e.data) begin
            n_bad++; $display("[TB] FAIL div3_data: got %h expected %h", rsp_data3, e.data);
        end
        @(negedge clk);
        n_cmp++;
        if (run_min3 !== DIV_B || run_max3 !== DIV_B) begin
            n_bad++; $display("[TB] FAIL div3_phase: got min %0d max %0d expected %0d",
                              run_min3, run_max3, DIV_B);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int k;
        bit seen_rsp;
        miso_word1 = 32'hCAFEF00D;
        req_addr1  = 24'h3C5A7E;
        req_valid1 = 1'b1;
        k = 0;
        while (!req_ready1 && k < 200) begin @(negedge clk); k++; end
        @(negedge clk);
        req_valid1 = 1'b0;
        exp_q.push_back('{data: le_word(32'hCAFEF00D), hdr: {8'h03, 24'h3C5A7E}});
        repeat (40 * DIV_A) @(negedge clk);
        n_cmp++;
        if (nbits1 !== 20 || fcsn1 !== 1'b0) begin
            n_bad++; $display("[TB] FAIL mid_position: got %0d bits csn %b expected 20 bits csn 0", nbits1, fcsn1);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        n_cmp++;
        if ({fcsn1, fclk1, rsp_valid1, req_ready1} !== 4'b1000) begin
            n_bad++; $display("[TB] FAIL mid_reset_pins: got %b expected 1000",
                              {fcsn1, fclk1, rsp_valid1, req_ready1});
        end
        seen_rsp = 1'b0;
        repeat (3) begin @(negedge clk); seen_rsp |= rsp_valid1; end
        rst = 1'b0;
        k = 0;
        while (fcsn1 !== 1'b0 && k < 50) begin @(negedge clk); seen_rsp |= rsp_valid1; k++; end
        k = 0;
        while (fcsn1 === 1'b0 && k < 200) begin @(negedge clk); seen_rsp |= rsp_valid1; k++; end
        n_cmp++;
        if (nbits1 !== 8 || mosi1[7:0] !== 8'hAB) begin
            n_bad++; $display("[TB] FAIL mid_rewake: got %0d bits %h expected 8 bits ab", nbits1, mosi1[7:0]);
        end
        n_cmp++;
        if (seen_rsp !== 1'b0) begin
            n_bad++; $display("[TB] FAIL mid_no_rsp: got %b expected 0", seen_rsp);
        end
    endtask

    task automatic test_req_during_wake();
        int e_cyc, acc, lat;
        logic [1:0] t1;
        exp_t e;
        e_cyc = cyc;
        exp_q.push_back('{data: le_word(32'h5A5AC3C3), hdr: 32'h03123456});
        do_read1(24'h123456, 32'h5A5AC3C3, 1'b0, acc, lat, t1);
        e = exp_q.pop_front();
        n_cmp++;
        if (acc - e_cyc !== WAKE_CYC + GAP_CYC) begin
            n_bad++; $display("[TB] FAIL wake_hold_accept: got %0d expected %0d", acc - e_cyc, WAKE_CYC + GAP_CYC);
        end
        n_cmp++;
        if (lat !== 1 + 128 * DIV_A) begin
            n_bad++; $display("[TB] FAIL wake_hold_latency: got %0d expected %0d", lat, 1 + 128 * DIV_A);
        end
        n_cmp++;
        if (rsp_data1 !== e.data) begin
            n_bad++; $display("[TB] FAIL wake_hold_data: got %h expected %h", rsp_data1, e.data);
        end
        n_cmp++;
        if (mosi1[63:32] !== e.hdr) begin
            n_bad++; $display("[TB] FAIL wake_hold_mosi: got %h expected %h", mosi1[63:32], e.hdr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_clkdiv3();
        test_reset_mid_xfer();
        test_req_during_wake();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
